// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port arbiter: FSM state encoding,
// owner encoding, default latency and the latency-counter width helper.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int unsigned MEM_LAT_DEFAULT = 4;

  // One spare bit above clog2 so MEM_LAT-1 always fits, including MEM_LAT=1.
  function automatic int unsigned lat_cnt_width(input int unsigned lat);
    return $clog2(lat) + 1;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag, used to time the fixed memory latency.
module mem_lat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory between the fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT,
  parameter int unsigned AW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_stall,
  output logic          i_valid,
  output logic [15:0]   i_data,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [15:0]   d_wdata,
  output logic          d_stall,
  output logic          d_valid,
  output logic [15:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata
);

  localparam int unsigned           CNT_W    = lat_cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          grant_own;
  logic          cnt_zero;
  logic          done;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On a collision the port that did not win last time goes first.
  always_comb begin
    if (i_req && d_req) begin
      grant_own = (last_grant_q == OWN_D) ? OWN_I : OWN_D;
    end else begin
      grant_own = d_req ? OWN_D : OWN_I;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == ST_IDLE) && (i_req || d_req)) begin
      last_grant_d = grant_own;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= OWN_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    grant_own = d_req ? OWN_D : OWN_I;
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d = ST_ISSUE;
          owner_d = grant_own;
          if (grant_own == OWN_D) begin
            wr_d    = d_wr;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            wr_d    = 1'b0;
            addr_d  = i_addr;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_I;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  mem_lat_counter #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == ST_ISSUE),
    .load_val_i (CNT_LOAD),
    .dec_i      ((state_q == ST_WAIT) && !cnt_zero),
    .zero_o     (cnt_zero)
  );

  // wr_q is forced low on fetch grants, so mem_wr needs no owner qualification.
  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_wr    = mem_en && wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign done      = (state_q == ST_WAIT) && cnt_zero;
  assign i_valid   = done && (owner_q == OWN_I);
  assign d_valid   = done && (owner_q == OWN_D);
  assign i_data    = i_valid ? mem_rdata : '0;
  assign d_rdata   = d_valid ? mem_rdata : '0;
  assign i_stall   = i_req && !i_valid;
  assign d_stall   = d_req && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter at MEM_LAT=4.
// Collision expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_stall, i_valid;
  logic [15:0] i_data;
  logic        d_req, d_wr;
  logic [15:0] d_addr, d_wdata;
  logic        d_stall, d_valid;
  logic [15:0] d_rdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [5:0]  flags;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  mem_port_arbiter #(
    .MEM_LAT (4),
    .AW      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_stall   (i_stall),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_stall   (d_stall),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign flags = {i_stall, i_valid, d_stall, d_valid, mem_en, mem_wr};

  // Advance to the start of cycle c; memory read data tags the cycle number.
  task automatic next_cycle(input int c);
    @(posedge clk);
    #1;
    mem_rdata = 16'hC000 | 16'(c);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = 16'h5555;
    next_cycle(0);
    next_cycle(0);
    @(negedge clk);
    n_total++;
    if (flags !== 6'b0) $display("FAIL reset_flags got %b want %b", flags, 6'b0);
    else n_pass++;
    n_total++;
    if ({i_data, d_rdata} !== 32'h0) $display("FAIL reset_data got %h want 0", {i_data, d_rdata});
    else n_pass++;
    n_total++;
    if ({mem_addr, mem_wdata} !== 32'h0) $display("FAIL reset_mem got %h want 0", {mem_addr, mem_wdata});
    else n_pass++;
    rst = 1'b0;
    next_cycle(0);
  endtask

  task automatic test_single_fetch();
    logic [5:0]  ef;
    logic [15:0] ed;
    next_cycle(0);
    i_req = 1'b1; i_addr = 16'h0010;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ef = {(c <= 4) ? 1'b1 : 1'b0, (c == 5) ? 1'b1 : 1'b0, 2'b00, (c == 1) ? 1'b1 : 1'b0, 1'b0};
      ed = (c == 5) ? (16'hC000 | 16'(c)) : 16'h0000;
      n_total++;
      if (flags !== ef) $display("FAIL fetch_flags c=%0d got %b want %b", c, flags, ef);
      else n_pass++;
      n_total++;
      if (i_data !== ed) $display("FAIL fetch_data c=%0d got %h want %h", c, i_data, ed);
      else n_pass++;
      if (c == 1) begin
        n_total++;
        if (mem_addr !== 16'h0010) $display("FAIL fetch_addr got %h want 0010", mem_addr);
        else n_pass++;
      end
      next_cycle(c + 1);
      if (c == 5) i_req = 1'b0;
    end
  endtask

  task automatic test_data_write();
    logic [5:0]  ef;
    logic [15:0] ed;
    next_cycle(0);
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h8000; d_wdata = 16'hBEEF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ef = {2'b00, (c <= 4) ? 1'b1 : 1'b0, (c == 5) ? 1'b1 : 1'b0,
            (c == 1) ? 1'b1 : 1'b0, (c == 1) ? 1'b1 : 1'b0};
      ed = (c == 5) ? (16'hC000 | 16'(c)) : 16'h0000;
      n_total++;
      if (flags !== ef) $display("FAIL write_flags c=%0d got %b want %b", c, flags, ef);
      else n_pass++;
      n_total++;
      if (d_rdata !== ed) $display("FAIL write_rdata c=%0d got %h want %h", c, d_rdata, ed);
      else n_pass++;
      if (c == 1) begin
        n_total++;
        if ({mem_addr, mem_wdata} !== {16'h8000, 16'hBEEF})
          $display("FAIL write_mem got %h want 8000beef", {mem_addr, mem_wdata});
        else n_pass++;
      end
      next_cycle(c + 1);
      if (c == 5) begin d_req = 1'b0; d_wr = 1'b0; end
    end
  endtask

  // Both ports raise requests together; first_d selects which one is expected to win.
  task automatic test_collision(input logic first_d);
    logic        w_st, w_vl, l_st, l_vl, en;
    logic [5:0]  ef;
    logic [15:0] edi, edd, ea;
    next_cycle(0);
    i_req = 1'b1; i_addr = 16'h0040;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200; d_wdata = 16'h7777;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      w_st = (c <= 4);  w_vl = (c == 5);
      l_st = (c <= 10); l_vl = (c == 11);
      en   = (c == 1) || (c == 7);
      ef = first_d ? {l_st, l_vl, w_st, w_vl, en, 1'b0} : {w_st, w_vl, l_st, l_vl, en, 1'b0};
      edi = ((first_d ? l_vl : w_vl) != 1'b0) ? (16'hC000 | 16'(c)) : 16'h0000;
      edd = ((first_d ? w_vl : l_vl) != 1'b0) ? (16'hC000 | 16'(c)) : 16'h0000;
      n_total++;
      if (flags !== ef) $display("FAIL coll_flags c=%0d got %b want %b", c, flags, ef);
      else n_pass++;
      n_total++;
      if ({i_data, d_rdata} !== {edi, edd})
        $display("FAIL coll_data c=%0d got %h want %h", c, {i_data, d_rdata}, {edi, edd});
      else n_pass++;
      if (en) begin
        ea = ((c == 1) == first_d) ? 16'h0200 : 16'h0040;
        n_total++;
        if (mem_addr !== ea) $display("FAIL coll_addr c=%0d got %h want %h", c, mem_addr, ea);
        else n_pass++;
        if (ea == 16'h0200) begin
          n_total++;
          if (mem_wdata !== 16'h7777) $display("FAIL coll_wdata got %h want 7777", mem_wdata);
          else n_pass++;
        end
      end
      next_cycle(c + 1);
      if (c == 5) begin
        if (first_d) d_req = 1'b0; else i_req = 1'b0;
      end
      if (c == 11) begin i_req = 1'b0; d_req = 1'b0; end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0]  ef;
    logic [15:0] ed;
    next_cycle(0);
    i_req = 1'b1; i_addr = 16'h0020;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ef = {((c <= 2) || ((c >= 5) && (c <= 9))) ? 1'b1 : 1'b0, (c == 10) ? 1'b1 : 1'b0,
            2'b00, ((c == 1) || (c == 6)) ? 1'b1 : 1'b0, 1'b0};
      ed = (c == 10) ? (16'hC000 | 16'(c)) : 16'h0000;
      n_total++;
      if (flags !== ef) $display("FAIL rstmid_flags c=%0d got %b want %b", c, flags, ef);
      else n_pass++;
      n_total++;
      if (i_data !== ed) $display("FAIL rstmid_data c=%0d got %h want %h", c, i_data, ed);
      else n_pass++;
      if (c == 4) begin
        n_total++;
        if ({mem_addr, mem_wdata} !== 32'h0)
          $display("FAIL rstmid_mem got %h want 0", {mem_addr, mem_wdata});
        else n_pass++;
      end
      if (c == 6) begin
        n_total++;
        if (mem_addr !== 16'h0030) $display("FAIL rstmid_addr got %h want 0030", mem_addr);
        else n_pass++;
      end
      next_cycle(c + 1);
      if (c == 2) begin rst = 1'b1; i_req = 1'b0; end
      if (c == 3) rst = 1'b0;
      if (c == 4) begin i_req = 1'b1; i_addr = 16'h0030; end
      if (c == 10) i_req = 1'b0;
    end
  endtask

  task automatic test_drop();
    logic [5:0]  ef;
    logic [15:0] edi, edd;
    next_cycle(0);
    i_req = 1'b1; i_addr = 16'h0050;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      ef = {(c <= 1) ? 1'b1 : 1'b0, (c == 5) ? 1'b1 : 1'b0,
            ((c >= 3) && (c <= 10)) ? 1'b1 : 1'b0, (c == 11) ? 1'b1 : 1'b0,
            ((c == 1) || (c == 7)) ? 1'b1 : 1'b0, 1'b0};
      edi = (c == 5)  ? (16'hC000 | 16'(c)) : 16'h0000;
      edd = (c == 11) ? (16'hC000 | 16'(c)) : 16'h0000;
      n_total++;
      if (flags !== ef) $display("FAIL drop_flags c=%0d got %b want %b", c, flags, ef);
      else n_pass++;
      n_total++;
      if ({i_data, d_rdata} !== {edi, edd})
        $display("FAIL drop_data c=%0d got %h want %h", c, {i_data, d_rdata}, {edi, edd});
      else n_pass++;
      if (c == 7) begin
        n_total++;
        if (mem_addr !== 16'h0600) $display("FAIL drop_addr got %h want 0600", mem_addr);
        else n_pass++;
      end
      next_cycle(c + 1);
      if (c == 1) i_req = 1'b0;
      if (c == 2) begin d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0600; end
      if (c == 11) d_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
`ifdef MEM_ARB_RR_EN
    test_collision(1'b0);
`else
    test_collision(1'b1);
`endif
    test_reset_mid();
    test_drop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
